// File: rtl/endless_wave_pkg.sv
// Shared constants, colours and ship sequencer state type for Endless Wave.
// Used by ship_updater (optional SHIP_WALL_KILL_EN) and box_scanner.
package endless_wave_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int SHIP_SIZE = 8;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;

   localparam logic [7:0] SHIP_X      = 8'd20;
   localparam logic [6:0] START_Y     = 7'd56;
   localparam logic [6:0] STEP        = 7'd1;
   localparam logic [2:0] SHIP_COLOUR = 3'b010;
   localparam logic [6:0] MAX_Y       = 7'(SCREEN_H - SHIP_SIZE);

   typedef enum logic [2:0] {
      INIT_DRAW,
      IDLE,
      CHK_START,
      CHK_ARM,
      CHK_WAIT,
      ERASE,
      DRAW,
      DEAD
   } ship_state_t;

endpackage

// File: rtl/ship_updater_if.sv
// Handshake between the ship sequencer and the 8x8 collision checker.
// master = ship_updater, slave = collision checker.
interface ship_updater_if;

   logic       check_start;
   logic [7:0] ref_x;
   logic [6:0] ref_y;
   logic       ship_dir;
   logic       check_done;
   logic       check_collision;

   modport master (
      output check_start, ref_x, ref_y, ship_dir,
      input  check_done, check_collision
   );

   modport slave (
      input  check_start, ref_x, ref_y, ship_dir,
      output check_done, check_collision
   );

endinterface

// File: rtl/ship_updater_box_scanner.sv
// 8x8 raster counter, row-major with x fastest, one pixel per cycle.
// A start on the last pixel restarts seamlessly with no gap.
import endless_wave_pkg::*;

module box_scanner (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] baseX,
   input  logic [6:0] baseY,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       valid,
   output logic       last
);

   logic [2:0] col;
   logic [2:0] row;

   assign last = valid && (&{col, row});

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         x     <= '0;
         y     <= '0;
         col   <= '0;
         row   <= '0;
         valid <= 1'b0;
      end else if (start) begin
         x     <= baseX;
         y     <= baseY;
         col   <= '0;
         row   <= '0;
         valid <= 1'b1;
      end else if (valid) begin
         if (last) begin
            valid <= 1'b0;
         end else if (col == 3'd7) begin
            col <= '0;
            row <= row + 3'd1;
            x   <= x - 8'd7;
            y   <= y + 7'd1;
         end else begin
            col <= col + 3'd1;
            x   <= x + 8'd1;
         end
      end
   end

endmodule

// File: rtl/ship_updater.sv
// Per-frame ship sequencer: move, collision check, erase and redraw.
// Optional SHIP_WALL_KILL_EN: hitting row 0 or row 112 kills the ship.
import endless_wave_pkg::*;

module ship_updater (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  tick,
   input  logic                  dir_in,
   ship_updater_if.master        chk,
   output logic [7:0]            x,
   output logic [6:0]            y,
   output logic [2:0]            colour,
   output logic                  writeEn,
   output logic [6:0]            ship_y,
   output logic                  game_over,
   output logic                  busy
);

   ship_state_t state;

   logic [6:0] newY;
   logic [6:0] refY;
   logic       shipDir;
   logic       checkStart;

   logic [7:0] sumY;
   logic       underY;
   logic       overY;
   logic [6:0] clampY;

   logic       scanStart;
   logic       scanLast;
   logic [6:0] scanBaseY;
   logic [2:0] scanColour;

   assign chk.check_start = checkStart;
   assign chk.ref_x       = SHIP_X;
   assign chk.ref_y       = refY;
   assign chk.ship_dir    = shipDir;

   // 8-bit sum so moving up from row 0 shows as bit 7 instead of wrapping
   always_comb begin
      sumY   = dir_in ? ({1'b0, ship_y} - {1'b0, STEP})
                      : ({1'b0, ship_y} + {1'b0, STEP});
      underY = sumY[7];
      overY  = !sumY[7] && (sumY > {1'b0, MAX_Y});
      clampY = underY ? 7'd0 : (overY ? MAX_Y : sumY[6:0]);
   end

   assign scanStart =
      (state == INIT_DRAW && !writeEn) ||
      (state == CHK_WAIT && chk.check_done && !chk.check_collision) ||
      (state == ERASE && scanLast);

   assign scanBaseY  = (state == ERASE) ? newY : ship_y;
   assign scanColour = (state == CHK_WAIT) ? BLACK : SHIP_COLOUR;

   box_scanner u_scan (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (scanStart),
      .baseX   (SHIP_X),
      .baseY   (scanBaseY),
      .x       (x),
      .y       (y),
      .valid   (writeEn),
      .last    (scanLast)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= INIT_DRAW;
         ship_y     <= START_Y;
         newY       <= '0;
         refY       <= '0;
         shipDir    <= 1'b0;
         checkStart <= 1'b0;
         game_over  <= 1'b0;
         busy       <= 1'b0;
         colour     <= '0;
      end else begin
         checkStart <= 1'b0;
         if (scanStart) colour <= scanColour;
         unique case (state)
            INIT_DRAW: begin
               busy <= 1'b1;
               if (scanLast) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (tick) begin
                  shipDir <= dir_in;
                  newY    <= clampY;
                  refY    <= dir_in ? clampY + 7'd7 : clampY;
`ifdef SHIP_WALL_KILL_EN
                  if (underY || overY) begin
                     game_over <= 1'b1;
                     state     <= DEAD;
                  end else begin
                     checkStart <= 1'b1;
                     busy       <= 1'b1;
                     state      <= CHK_START;
                  end
`else
                  checkStart <= 1'b1;
                  busy       <= 1'b1;
                  state      <= CHK_START;
`endif
               end
            end
            CHK_START: state <= CHK_ARM;
            CHK_ARM:   state <= CHK_WAIT;
            CHK_WAIT: begin
               if (chk.check_done) begin
                  if (chk.check_collision) begin
                     game_over <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DEAD;
                  end else begin
                     state <= ERASE;
                  end
               end
            end
            ERASE: begin
               if (scanLast) state <= DRAW;
            end
            DRAW: begin
               if (scanLast) begin
                  ship_y <= newY;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            DEAD: state <= DEAD;
            default: state <= INIT_DRAW;
         endcase
      end
   end

endmodule

// File: tb/tb_ship_updater.sv
// Randomized scoreboard bench for ship_updater with a collision checker model.
// Honours SHIP_WALL_KILL_EN for the wall boundary expectations.
import endless_wave_pkg::*;

module tb_ship_updater;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       dir_in = 1'b0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       writeEn;
   logic [6:0] ship_y;
   logic       game_over;
   logic       busy;
   logic       nextColl = 1'b0;

   ship_updater_if chk();

   ship_updater dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick      (tick),
      .dir_in    (dir_in),
      .chk       (chk),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .writeEn   (writeEn),
      .ship_y    (ship_y),
      .game_over (game_over),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   typedef struct packed {
      logic [6:0] ry;
      logic       rd;
   } chk_t;

   pix_t wQ[$];
   chk_t cQ[$];
   int   checks = 0;
   int   errors = 0;
   int   modelY = 56;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pushBox(input int by, input logic [2:0] c);
      pix_t p;
      for (int r = 0; r < 8; r++)
         for (int cc = 0; cc < 8; cc++) begin
            p.px = 8'(20 + cc);
            p.py = 7'(by + r);
            p.pc = c;
            wQ.push_back(p);
         end
   endtask

   always @(negedge clock) begin : monitor
      pix_t e;
      chk_t ec;
      if (reset_n) begin
         if (writeEn) begin
            if (wQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL write: unexpected pixel x=%0d y=%0d c=%0d",
                        x, y, colour);
            end else begin
               e = wQ.pop_front();
               check("pix_x", 32'(x), 32'(e.px));
               check("pix_y", 32'(y), 32'(e.py));
               check("pix_colour", 32'(colour), 32'(e.pc));
            end
         end
         if (chk.check_start) begin
            if (cQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL check_start: unexpected pulse ref_y=%0d",
                        chk.ref_y);
            end else begin
               ec = cQ.pop_front();
               check("ref_y", 32'(chk.ref_y), 32'(ec.ry));
               check("ship_dir", 32'(chk.ship_dir), 32'(ec.rd));
               check("ref_x", 32'(chk.ref_x), 32'd20);
            end
         end
      end
   end

   initial begin : checker_model
      chk.check_done      = 1'b1;
      chk.check_collision = 1'b0;
      forever begin
         @(negedge clock);
         if (chk.check_start) begin
            @(posedge clock);
            #1 chk.check_done = 1'b0;
            repeat ($urandom_range(0, 4)) @(posedge clock);
            @(posedge clock);
            #1;
            chk.check_collision = nextColl;
            chk.check_done      = 1'b1;
         end
      end
   end

   task automatic doTick(input logic d, input logic coll);
      int  ny;
      logic wall;
      @(posedge clock);
      #1;
      tick     = 1'b1;
      dir_in   = d;
      nextColl = coll;
      ny   = d ? modelY - 1 : modelY + 1;
      wall = (ny < 0) || (ny > 112);
      if (ny < 0) ny = 0;
      if (ny > 112) ny = 112;
`ifdef SHIP_WALL_KILL_EN
      if (!wall) begin
`else
      if (wall || !wall) begin
`endif
         cQ.push_back({7'(d ? ny + 7 : ny), d});
         if (!coll) begin
            pushBox(modelY, BLACK);
            pushBox(ny, SHIP_COLOUR);
            modelY = ny;
         end
      end
      @(posedge clock);
      #1 tick = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (n < 3000 && !(wQ.size() == 0 && cQ.size() == 0 && !busy)) begin
         @(negedge clock);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, %0d writes %0d checks pending",
                  name, wQ.size(), cQ.size());
      end
      @(negedge clock);
   endtask

   task automatic applyReset();
      reset_n = 1'b0;
      wQ.delete();
      cQ.delete();
      modelY = 56;
      repeat (3) @(posedge clock);
      #1;
      check("rst_writeEn", 32'(writeEn), 0);
      check("rst_xyc", {x, y, colour}, 0);
      check("rst_ship_y", 32'(ship_y), 56);
      check("rst_game_over", 32'(game_over), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_chk", {chk.check_start, chk.ref_y, chk.ship_dir}, 0);
      check("rst_ref_x", 32'(chk.ref_x), 20);
      pushBox(56, SHIP_COLOUR);
      reset_n = 1'b1;
      waitIdle("init_draw");
      check("init_ship_y", 32'(ship_y), 56);
      check("init_busy", 32'(busy), 0);
   endtask

   initial begin : stim
      int n;
      applyReset();

      doTick(1'b0, 1'b0);
      waitIdle("down_tick");
      check("down_ship_y", 32'(ship_y), 57);
      check("down_game_over", 32'(game_over), 0);

      repeat (12) begin
         repeat ($urandom_range(0, 5)) @(posedge clock);
         doTick(1'($urandom_range(0, 1)), 1'b0);
         waitIdle("rand_tick");
         check("rand_ship_y", 32'(ship_y), 32'(modelY));
      end

      doTick(1'($urandom_range(0, 1)), 1'b0);
      n = 0;
      while (!writeEn && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("erase_seen", 32'(writeEn), 1);
      @(posedge clock);
      #1 tick = 1'b1;
      @(posedge clock);
      #1 tick = 1'b0;
      waitIdle("tick_in_erase");
      check("erase_ship_y", 32'(ship_y), 32'(modelY));

      doTick(1'b0, 1'b0);
      n = 0;
      while (!(writeEn && colour == SHIP_COLOUR) && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("draw_seen", 32'(writeEn), 1);
      @(posedge clock);
      #1 reset_n = 1'b0;
      @(posedge clock);
      #2;
      check("mid_rst_writeEn", 32'(writeEn), 0);
      check("mid_rst_game_over", 32'(game_over), 0);
      applyReset();

      while (modelY > 0) begin
         doTick(1'b1, 1'b0);
         waitIdle("climb");
      end
      check("top_ship_y", 32'(ship_y), 0);
      doTick(1'b1, 1'b0);
      waitIdle("wall_tick");
      check("wall_ship_y", 32'(ship_y), 0);
`ifdef SHIP_WALL_KILL_EN
      check("wall_game_over", 32'(game_over), 1);
`else
      check("wall_game_over", 32'(game_over), 0);
`endif

      applyReset();
      doTick(1'b1, 1'b1);
      waitIdle("collide");
      check("coll_game_over", 32'(game_over), 1);
      check("coll_busy", 32'(busy), 0);
      check("coll_ship_y", 32'(ship_y), 56);
      repeat (3) begin
         @(posedge clock);
         #1 tick = 1'b1;
         @(posedge clock);
         #1 tick = 1'b0;
         repeat (5) @(posedge clock);
      end
      repeat (10) @(negedge clock);
      check("dead_game_over", 32'(game_over), 1);
      check("dead_writeEn", 32'(writeEn), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
